// File: rtl/util_reset_seq.sv
// Multi-channel reset sequencer: async assert, synchronised release,
// minimum pulse width, then channel-by-channel staggered release.
module util_reset_seq #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 3,
    parameter int MIN_PULSE   = 16,
    parameter int STAGGER     = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                soft_rst,
    input  logic [CHANNELS-1:0] ch_hold,
    output logic [CHANNELS-1:0] rst_out,
    output logic                done
);

    localparam int MAXC = (MIN_PULSE > STAGGER) ? MIN_PULSE : STAGGER;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0] PULSE_LAST = CW'(MIN_PULSE - 1);
    localparam logic [CW-1:0] STAG_LAST  = CW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_RELEASE,
        S_DONE
    } state_t;

    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGES-1:0] sync_q;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [CHANNELS-1:0]   rst_q;
    logic                  done_q;
    logic                  run;
    logic                  due;
    logic                  hold_cur;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign run = sync_q[SYNC_STAGES-1];
    assign due = (cnt == STAG_LAST);

    always_comb begin
        hold_cur = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IW'(i)) hold_cur = ch_hold[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_ASSERT;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
        end else if (soft_rst) begin
            state  <= S_ASSERT;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
        end else if (run) begin
            unique case (state)
                S_ASSERT: begin
                    if (cnt == PULSE_LAST) begin
                        rst_q[0] <= 1'b0;
                        cnt      <= '0;
                        if (CHANNELS == 1) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_RELEASE;
                            idx   <= IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (due && !hold_cur) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (idx == IW'(i)) rst_q[i] <= 1'b0;
                        end
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else if (!due) begin
                        // hold the count at the due value while blocked
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_ASSERT;
                end
            endcase
        end
    end

    assign rst_out = rst_q;
    assign done    = done_q;

endmodule

// File: tb/tb_util_reset_seq.sv
// Directed bench for util_reset_seq: release schedules, hold, soft reset,
// async assertion and the single-channel corner.
module tb_util_reset_seq;

    typedef struct packed {
        logic [3:0]      hm;
        logic [7:0]      hf;
        logic [7:0]      ht;
        logic [7:0]      sl;
        logic [7:0]      sh;
        logic [3:0][7:0] ra;
        logic [3:0][7:0] rb;
    } scn_t;

    logic       clk;
    logic       clk_en;
    logic       resetn;
    logic       soft_rst;
    logic [3:0] ch_hold;
    logic [3:0] rst_out;
    logic       done;

    logic       resetn1;
    logic       soft1;
    logic [0:0] hold1;
    logic [0:0] rst1;
    logic       done1;

    int nvec;
    int nfail;

    util_reset_seq u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .soft_rst (soft_rst),
        .ch_hold  (ch_hold),
        .rst_out  (rst_out),
        .done     (done)
    );

    util_reset_seq #(
        .CHANNELS    (1),
        .SYNC_STAGES (2),
        .MIN_PULSE   (1),
        .STAGGER     (8)
    ) u_edge (
        .clk      (clk),
        .resetn   (resetn1),
        .soft_rst (soft1),
        .ch_hold  (hold1),
        .rst_out  (rst1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int n,
                       input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s edge %0d: got %b, expected %b",
                     name, n, act, exp);
        end
    endtask

    function automatic scn_t mk(
        input logic [3:0] hm, input int hf, input int ht,
        input int sl, input int sh,
        input int a0, input int a1, input int a2, input int a3,
        input int b0, input int b1, input int b2, input int b3);
        scn_t s;
        s.hm = hm;
        s.hf = 8'(hf);
        s.ht = 8'(ht);
        s.sl = 8'(sl);
        s.sh = 8'(sh);
        s.ra = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        s.rb = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
        return s;
    endfunction

    task automatic run_scn(input int k, input scn_t s);
        logic [3:0] e;
        ch_hold  = 4'b0;
        soft_rst = 1'b0;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("s%0d_reset_rst", k), 0, rst_out, 4'b1111);
        chk($sformatf("s%0d_reset_done", k), 0, {3'b0, done}, 4'b0);
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 1; n <= 75; n++) begin
            ch_hold  = (n >= int'(s.hf) && n <= int'(s.ht)) ? s.hm : 4'b0;
            soft_rst = (s.sl != 0 && n >= int'(s.sl) && n <= int'(s.sh));
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (s.sl != 0 && n >= int'(s.sl)) e[i] = (n < int'(s.rb[i]));
                else e[i] = (n < int'(s.ra[i]));
            end
            chk($sformatf("s%0d_rst", k), n, rst_out, e);
            chk($sformatf("s%0d_done", k), n, {3'b0, done},
                {3'b0, (e == 4'b0)});
        end
        ch_hold  = 4'b0;
        soft_rst = 1'b0;
    endtask

    scn_t scns [5];

    initial begin
        nvec     = 0;
        nfail    = 0;
        clk_en   = 1'b1;
        resetn   = 1'b0;
        soft_rst = 1'b0;
        ch_hold  = 4'b0;
        resetn1  = 1'b0;
        soft1    = 1'b0;
        hold1    = 1'b0;

        // power-up, holds asserted only in DONE
        scns[0] = mk(4'hF, 50, 75, 0, 0,  19, 27, 35, 43,  0, 0, 0, 0);
        // channel 1 held through edge 39
        scns[1] = mk(4'h2, 1, 39, 0, 0,   19, 40, 48, 56,  0, 0, 0, 0);
        // soft reset at edge 30 only
        scns[2] = mk(4'h0, 0, 0, 30, 30,  19, 27, 35, 43,  46, 54, 62, 70);
        // soft reset 27..29 collides with channel 1 due at 27
        scns[3] = mk(4'h0, 0, 0, 27, 29,  19, 27, 35, 43,  45, 53, 61, 69);
        // hold on an already released channel is ignored
        scns[4] = mk(4'h1, 20, 75, 0, 0,  19, 27, 35, 43,  0, 0, 0, 0);

        for (int k = 0; k < 5; k++) begin
            run_scn(k, scns[k]);
            if (k == 0) begin
                #2;
                resetn = 1'b0;
                #1;
                chk("async_rst", 0, rst_out, 4'b1111);
                chk("async_done", 0, {3'b0, done}, 4'b0);
            end
            if (k == 3) begin
                @(negedge clk);
                clk_en = 1'b0;
                #20;
                resetn = 1'b0;
                #1;
                chk("stopped_rst", 0, rst_out, 4'b1111);
                chk("stopped_done", 0, {3'b0, done}, 4'b0);
                #20;
                chk("stopped_rst_hold", 0, rst_out, 4'b1111);
                clk_en = 1'b1;
            end
        end

        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("edge_reset_rst", 0, {3'b0, rst1}, 4'b0001);
        chk("edge_reset_done", 0, {3'b0, done1}, 4'b0);
        @(negedge clk);
        resetn1 = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            chk("edge_rst", n, {3'b0, rst1}, {3'b0, (n < 3)});
            chk("edge_done", n, {3'b0, done1}, {3'b0, (n >= 3)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/util_reset_seq.md
# util_reset_seq

Multi-channel reset sequencer that replaces single-output reset synchronisers where several downstream domains must leave reset in a fixed order. Reset asserts asynchronously on all channels at once. Release is synchronised to `clk`, held for a minimum pulse width, then staggered channel by channel. Each channel can be held in reset by its consumer, and a synchronous soft-reset request restarts the sequence without toggling the master reset.

## Interface
- `CHANNELS`, 4: number of reset outputs; must be ≥ 1.
- `SYNC_STAGES`, 3: depth of the deassertion synchroniser; must be ≥ 2. Chain flops carry ASYNC_REG.
- `MIN_PULSE`, 16: cycles all outputs stay asserted after the synchronised release or soft reset; must be ≥ 1.
- `STAGGER`, 8: cycles between release of channel i and channel i+1; must be ≥ 1.

Ports:
- `clk`, input, 1: single clock; all logic runs on its rising edge.
- `resetn`, input, 1: master reset, asynchronous, active-low.
- `soft_rst`, input, 1: synchronous to `clk`, active-high; a restart request.
- `ch_hold`, input, CHANNELS: synchronous, active-high; bit i postpones release of channel i.
- `rst_out`, output, CHANNELS: active-high resets; bit 0 is released first.
- `done`, output, 1: high once all channels are released.

## Operation
- **States:**
  - ASSERT: counting MIN_PULSE.
  - RELEASE: index `idx` plus stagger counter.
  - DONE.
- **While `resetn` = 0:**
  - `rst_out` is all ones, asynchronously, with no clock needed.
  - `done` = 0, state is ASSERT, counters are 0, synchroniser is 0.
- **Synchroniser:** after `resetn` rises, a 1 shifts through SYNC_STAGES flops. The sequencer starts counting when the last stage is 1.
- **ASSERT:** after MIN_PULSE counted cycles, release channel 0 and enter RELEASE with `idx` = 1.
  - If CHANNELS = 1, go directly to DONE with `done` = 1 in the same cycle.
- **RELEASE:** STAGGER cycles after the previous release, channel `idx` becomes due.
  - The channel is released on the first edge at which it is due and `ch_hold[idx]` is sampled 0.
  - The stagger count for the next channel restarts from that actual release edge.
  - Order is strict: a held channel blocks all higher channels.
  - Releasing channel CHANNELS-1 moves to DONE and sets `done` = 1 on the same edge.
- **Released channels:** `ch_hold` has no effect on a channel that is already released, and none in DONE.
- **soft_rst:** when sampled 1 in any state, all `rst_out` bits go to 1 and `done` goes to 0 on that edge.
  - State becomes ASSERT and the pulse counter clears.
  - While `soft_rst` stays high, the counter is held at 0.
  - `soft_rst` wins over any release due on the same edge.
- **resetn mid-sequence:** `resetn` falling at any point overrides everything immediately and asynchronously, and clears the synchroniser.
- **Glitch-free outputs:** every `rst_out` bit and `done` come straight from flops. `rst_out` flops use an asynchronous set and `done` uses an asynchronous clear. There is no combinational path to any output.
- **Counter width:** $clog2 of max(MIN_PULSE, STAGGER) plus one bit. Counters saturate and never wrap.

## Timing
- Edge numbering for `resetn`: edge 1 is the first rising `clk` edge after `resetn` rises.
  - The synchroniser's last stage is 1 after edge SYNC_STAGES.
  - Channel 0 is released at edge SYNC_STAGES + MIN_PULSE.
  - With no hold, channel i is released at edge SYNC_STAGES + MIN_PULSE + i·STAGGER.
  - `done` rises on the same edge as the last channel's release.
- Defaults (3 / 16 / 8, 4 channels): channel releases at edges 19, 27, 35, 43; `done` at edge 43.
- Soft reset: if `soft_rst` is last sampled 1 at edge e, channel 0 is released at edge e + MIN_PULSE. Channel i follows at edge e + MIN_PULSE + i·STAGGER.
- Hold: channel i is released at edge max(due edge, first edge with `ch_hold[i]` = 0). Channel i+1 is due STAGGER edges after that.
- Assertion latency:
  - `resetn` falling: combinational through the asynchronous set, 0 cycles.
  - `soft_rst`: 1 edge.

## Test plan
- **Power-up, defaults:** pulse `resetn` low, then release it. `rst_out` goes 1111 → 1110 @19 → 1100 @27 → 1000 @35 → 0000 @43. `done` rises at edge 43.
- **Asynchronous assert:** drop `resetn` in DONE between clock edges. `rst_out` = 1111 and `done` = 0 before the next edge. Also check `rst_out` = 1111 with `clk` stopped.
- **Hold:** `ch_hold[1]` = 1 until edge 40, then 0. Channel 1 releases at 40 (not 27), channel 2 at 48, channel 3 at 56, `done` at 56.
- **Soft reset mid-sequence:** `soft_rst` high at edge 30 only. All channels reassert at edge 30. Channel 0 releases at 46, then 54, 62, 70, with `done` at 70.
- **Collisions:** `soft_rst` held high at edges 27–29 with channel 1 due at 27. Channel 1 stays asserted and channel 0 reasserts at 27. Channel 0 releases at 45.
- **Edge parameters:** CHANNELS = 1, MIN_PULSE = 1, SYNC_STAGES = 2. `rst_out` releases and `done` rises together at edge 3.
